pipeline_hazard_ctrl: RTL

Central stall/flush sequencer for the five-stage pipeline. It drives the load-enable and flush/bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, handles load-use hazards and taken-branch/jump squashes, and runs the handshake with a variable-latency data memory for the memory operation held in EX/MEM. It also detects memory timeouts.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 22 ++
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 25 ++
 rtl/pipeline_hazard_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    // Sequencer states: normal run, waiting on data memory, memory timeout.
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    // Register-number width and the hard-wired zero register.
    localparam int                REG_W    = 5;
    localparam logic [REG_W-1:0] ZERO_REG = '0;

    // True when a producer's destination matches a consumer's source,
    // ignoring the zero register (it is never a real dependence).
    function automatic logic reg_match(input logic [REG_W-1:0] dst,
                                       input logic [REG_W-1:0] src);
        return (dst != ZERO_REG) && (dst == src);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard detector: the load in ID/EX writes a register that the
// instruction in ID reads, so ID must wait one cycle for the load data.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_uses_rt,
    input  logic             i_idex_memread,
    input  logic [REG_W-1:0] i_idex_rd,
    output logic             o_lu_hazard
);

    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit = reg_match(i_idex_rd, i_id_rs);
    assign w_rt_hit = i_id_uses_rt && reg_match(i_idex_rd, i_id_rt);

    // Hazard only exists when the ID/EX instruction is actually a load.
    always_comb begin
        o_lu_hazard = i_idex_memread && (w_rs_hit || w_rt_hit);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline.
// Memory handshake: o_dmem_req is held high until i_dmem_ack; an ack in the
// same cycle as the request completes the access with no stall. While a
// request is outstanding the pipeline is frozen and MEM/WB takes bubbles.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CW      = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_uses_rt,
    input  logic             i_id_jump,
    input  logic             i_idex_memread,
    input  logic [REG_W-1:0] i_idex_rd,
    input  logic             i_ex_branch_taken,
    input  logic             i_exmem_memread,
    input  logic             i_exmem_memwrite,
    input  logic             i_dmem_ack,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_idex_en,
    output logic             o_exmem_en,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic             o_memwb_bubble,
    output logic             o_dmem_req,
    output logic             o_dmem_we,
    output logic             o_mem_err,
    output state_t           o_state,
    output logic [CW-1:0]    o_wait_cnt
);

    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_next_cnt;
    logic          r_mem_err;
    logic          w_set_err;
    logic          w_freeze;
    logic          w_req;
    logic          w_memop;
    logic          w_lu_hazard;

    assign w_memop = i_exmem_memread || i_exmem_memwrite;

    load_use_detect u_load_use_detect (
        .i_id_rs        (i_id_rs),
        .i_id_rt        (i_id_rt),
        .i_id_uses_rt   (i_id_uses_rt),
        .i_idex_memread (i_idex_memread),
        .i_idex_rd      (i_idex_rd),
        .o_lu_hazard    (w_lu_hazard)
    );

    // State, wait counter and sticky error flag.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_next_cnt;
            if (w_set_err) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    // Next state, counter, memory request and freeze decision.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_set_err    = 1'b0;
        w_freeze     = 1'b0;
        w_req        = 1'b0;
        case (r_state)
            RUN: begin
                w_req = w_memop;
                if (w_memop && !i_dmem_ack) begin
                    w_freeze     = 1'b1;
                    w_next_state = WAIT;
                    w_next_cnt   = '0;
                end
            end
            WAIT: begin
                w_req      = 1'b1;
                w_next_cnt = r_cnt + 1'b1;
                if (i_dmem_ack) begin
                    // Ack wins even on the last allowed wait cycle.
                    w_next_state = RUN;
                end else begin
                    w_freeze = 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        w_next_state = ERR;
                        w_set_err    = 1'b1;
                    end
                end
            end
            ERR: begin
                w_freeze = 1'b1;
            end
            default: begin
                w_freeze     = 1'b1;
                w_next_state = RUN;
            end
        endcase
    end

    // Priority mux: reset > memory freeze > branch > load-use > jump.
    always_comb begin
        o_pc_en        = 1'b1;
        o_ifid_en      = 1'b1;
        o_idex_en      = 1'b1;
        o_exmem_en     = 1'b1;
        o_ifid_flush   = 1'b0;
        o_idex_flush   = 1'b0;
        o_memwb_bubble = 1'b0;
        if (i_reset) begin
            o_pc_en    = 1'b0;
            o_ifid_en  = 1'b0;
            o_idex_en  = 1'b0;
            o_exmem_en = 1'b0;
        end else if (w_freeze) begin
            o_pc_en        = 1'b0;
            o_ifid_en      = 1'b0;
            o_idex_en      = 1'b0;
            o_exmem_en     = 1'b0;
            o_memwb_bubble = 1'b1;
        end else if (i_ex_branch_taken) begin
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
        end else if (w_lu_hazard) begin
            // Holding IF/ID also holds a jump in ID; it re-decodes next cycle.
            o_pc_en      = 1'b0;
            o_ifid_en    = 1'b0;
            o_idex_flush = 1'b1;
        end else if (i_id_jump) begin
            o_ifid_flush = 1'b1;
        end
    end

    // Memory-side outputs are forced low while reset is asserted.
    always_comb begin
        o_dmem_req = w_req && !i_reset;
        o_dmem_we  = i_exmem_memwrite && o_dmem_req;
        o_mem_err  = r_mem_err && !i_reset;
        o_state    = r_state;
        o_wait_cnt = r_cnt;
    end

endmodule
